// File: rtl/mux_func_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The state encoding is fixed so other lab blocks can decode it.
package mux_func_sweeper_pkg;

    localparam int N_IN_DEF = 5;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Down-counter that paces the HOLD phase: after a load with value S,
// expire_o is high in the S-th cycle following the load edge.
module sweep_settle_timer
    import mux_func_sweeper_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] settle_i,
    output logic                expire_o
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = settle_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - SETTLE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // A count of 1 marks the last HOLD cycle, so the FSM leaves HOLD on that edge.
    assign expire_o = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/mux_func_sweeper.sv
// Walks all 2**N_IN input vectors of an external function block, samples
// its output after SETTLE cycles and checks the captured table against expected.
module mux_func_sweeper
    import mux_func_sweeper_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2**N_IN-1:0]  expected,
    input  logic                y_in,
    output logic [N_IN-1:0]     vec_out,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  table_out,
    output logic                pass,
    output logic [N_IN:0]       fail_count,
    output logic [N_IN-1:0]     first_fail
);

    localparam int              DEPTH = 2**N_IN;
    localparam logic [N_IN-1:0] LAST  = '1;
    // With no settle time every vector goes straight to SAMPLE.
    localparam sweep_state_e    NEXT_ST = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

    sweep_state_e       state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [DEPTH-1:0]   table_q, table_d;
    logic [DEPTH-1:0]   exp_q, exp_d;
    logic [N_IN:0]      fail_q, fail_d;
    logic [N_IN-1:0]    ffail_q, ffail_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               load;
    logic               expire;

    sweep_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .settle_i (SETTLE_W'(SETTLE)),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        table_d = table_q;
        exp_d   = exp_q;
        fail_d  = fail_q;
        ffail_d = ffail_q;
        pass_d  = pass_q;
        done_d  = done_q;
        busy_d  = busy_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = NEXT_ST;
                    idx_d   = '0;
                    table_d = '0;
                    exp_d   = expected;
                    fail_d  = '0;
                    ffail_d = '0;
                    pass_d  = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (expire) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                table_d[idx_q] = y_in;
                if (y_in != exp_q[idx_q]) begin
                    fail_d = fail_q + (N_IN+1)'(1);
                    if (fail_q == '0) ffail_d = idx_q;
                end
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_d == '0);
                end else begin
                    state_d = NEXT_ST;
                    idx_d   = idx_q + N_IN'(1);
                    load    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            table_q <= '0;
            exp_q   <= '0;
            fail_q  <= '0;
            ffail_q <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            fail_q  <= fail_d;
            ffail_q <= ffail_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign vec_out    = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_out  = table_q;
    assign pass       = pass_q;
    assign fail_count = fail_q;
    assign first_fail = ffail_q;

endmodule

// File: tb/tb_mux_func_sweeper.sv
// Directed bench: three sweeper instances (SETTLE = 1, 3, 0) with
// hand-computed truth tables, latencies and fail statistics.
module tb_mux_func_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;       // [0]=u1, [1]=u3, [2]=u0
    logic [31:0] exp1 = '0, exp3 = 32'hAAAAAAAA, exp0 = 32'hFFFF0000;
    logic        ymode = 1'b0;

    logic [4:0]  vec1, vec3, vec0;
    logic        busy1, busy3, busy0, done1, done3, done0, pass1, pass3, pass0;
    logic [31:0] tab1, tab3, tab0;
    logic [5:0]  fc1, fc3, fc0;
    logic [4:0]  ff1, ff3, ff0;
    logic        y1, y3, y0, glitch;
    logic [2:0]  done_v;
    int          cyc3 = 0;

    int n_chk  = 0;
    int n_fail = 0;
    int edges;

    always #5 clk = ~clk;

    assign y1     = ymode ? 1'b1 : vec1[4];
    assign glitch = busy3 && (cyc3 % 4 != 3);
    assign y3     = vec3[0] ^ glitch;
    assign y0     = vec0[4];
    assign done_v = {done0, done3, done1};

    always @(posedge clk) cyc3 <= start_v[1] ? 0 : cyc3 + 1;

    mux_func_sweeper #(.N_IN(5), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .expected(exp1), .y_in(y1),
        .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tab1),
        .pass(pass1), .fail_count(fc1), .first_fail(ff1));

    mux_func_sweeper #(.N_IN(5), .SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .expected(exp3), .y_in(y3),
        .vec_out(vec3), .busy(busy3), .done(done3), .table_out(tab3),
        .pass(pass3), .fail_count(fc3), .first_fail(ff3));

    mux_func_sweeper #(.N_IN(5), .SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[2]), .expected(exp0), .y_in(y0),
        .vec_out(vec0), .busy(busy0), .done(done0), .table_out(tab0),
        .pass(pass0), .fail_count(fc0), .first_fail(ff0));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start edge is edge 0; returns the edge count at which done was seen high.
    task automatic run_sweep(input int which, input int restart_at, input int chg_at,
                             output int n);
        @(negedge clk);
        start_v[which] = 1'b1;
        @(posedge clk);
        #1 start_v[which] = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            start_v[which] = (n + 1 == restart_at);
            if (n == chg_at) exp1 = ~exp1;
            if (done_v[which]) break;
        end
        start_v[which] = 1'b0;
        if (!done_v[which]) check("sweep_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_vec",  vec1, 0);
        check("rst_tab",  tab1, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;

        // y = a, table matches
        ymode = 1'b0; exp1 = 32'hFFFF0000;
        run_sweep(0, -1, -1, edges);
        check("a_edges", edges, 64);
        check("a_tab",   tab1, 32'hFFFF0000);
        check("a_pass",  pass1, 1);
        check("a_fc",    fc1, 0);
        check("a_ff",    ff1, 0);
        check("a_busy",  busy1, 0);

        exp1 = 32'hFFFF0001;
        run_sweep(0, -1, -1, edges);
        check("b_pass", pass1, 0);
        check("b_fc",   fc1, 1);
        check("b_ff",   ff1, 0);

        ymode = 1'b1; exp1 = 32'h7FFFFFFF;
        run_sweep(0, -1, -1, edges);
        check("c_tab", tab1, 32'hFFFFFFFF);
        check("c_fc",  fc1, 1);
        check("c_ff",  ff1, 31);
        check("c_pass", pass1, 0);

        exp1 = 32'h0;
        run_sweep(0, -1, -1, edges);
        check("d_fc", fc1, 32);
        check("d_ff", ff1, 0);

        // restart at cycle 10 ignored; expected flipped at 20 ignored
        ymode = 1'b0; exp1 = 32'hFFFF0000;
        run_sweep(0, 10, 20, edges);
        check("e_edges", edges, 64);
        check("e_pass",  pass1, 1);
        check("e_fc",    fc1, 0);
        exp1 = 32'hFFFF0000;

        // async reset mid-sweep at cycle 20, at a random point inside the cycle
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (19) @(posedge clk);
        #($urandom_range(2, 8)) rst = 1'b1;
        #1;
        check("r_busy", busy1, 0);
        check("r_vec",  vec1, 0);
        check("r_done", done1, 0);
        check("r_fc",   fc1, 0);
        @(negedge clk) rst = 1'b0;
        run_sweep(0, -1, -1, edges);
        check("r2_edges", edges, 64);
        check("r2_tab",   tab1, 32'hFFFF0000);
        check("r2_pass",  pass1, 1);

        // SETTLE=3 with glitches only during HOLD
        run_sweep(1, -1, -1, edges);
        check("s3_edges", edges, 128);
        check("s3_tab",   tab3, 32'hAAAAAAAA);
        check("s3_pass",  pass3, 1);
        check("s3_fc",    fc3, 0);

        // SETTLE=0: one cycle per vector
        run_sweep(2, -1, -1, edges);
        check("s0_edges", edges, 32);
        check("s0_tab",   tab0, 32'hFFFF0000);
        check("s0_pass",  pass0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
